// File: rtl/mux_arbiter8_if.sv
// ============================================================================
//  Module   : mux_arbiter8_if
//  Purpose  : Request/grant bundle between eight requesters and mux_arbiter8.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface mux_arbiter8_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       new_grant;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  new_grant
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output new_grant
    );
endinterface

`default_nettype wire

// File: rtl/mux_arbiter8.sv
// ============================================================================
//  Module   : mux_arbiter8
//  Purpose  : Registered round-robin arbiter with per-tenure hold limit that
//             drives the select of a shared 8:1 bit-select mux.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_arbiter8 #(
    parameter int MAX_HOLD = 4
) (
    input  wire                 clk,
    input  wire                 rst_n,
    mux_arbiter8_if.slave       bus
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] c_MAX_HOLD = HW'(MAX_HOLD);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_owner;
    logic [2:0]      w_owner_nxt;
    logic [HW-1:0]   r_hold_cnt;
    logic [HW-1:0]   w_hold_nxt;
    logic [2:0]      r_ptr;
    logic [2:0]      w_ptr_nxt;
    logic [7:0]      r_gnt;
    logic [7:0]      w_gnt_nxt;
    logic            r_busy;
    logic            r_new_grant;
    logic            w_new_nxt;
    logic            w_take;
    logic [7:0]      w_cand;
    logic [7:0]      w_masked;
    logic [2:0]      w_win;

    // First set bit of cand scanning p, p+1, ... p+7 (mod 8); the downward
    // loop lets the lowest rotational offset overwrite the others.
    function automatic logic [2:0] f_winner(input logic [7:0] cand, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] win;
        win = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (cand[idx]) win = idx;
        end
        return win;
    endfunction

    assign w_masked = bus.req & ~(8'b1 << r_owner);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold_cnt;
        w_ptr_nxt   = r_ptr;
        w_new_nxt   = 1'b0;
        w_take      = 1'b0;
        w_cand      = bus.req;
        case (r_state)
            S_IDLE: begin
                w_take = |bus.req;
            end
            S_GRANT: begin
                if (!bus.req[r_owner]) begin
                    if (|bus.req) w_take = 1'b1;
                    else          w_state_nxt = S_IDLE;
                end else if (r_hold_cnt == c_MAX_HOLD) begin
                    // With nobody else waiting, the unmasked req holds only the owner.
                    w_take = 1'b1;
                    if (|w_masked) w_cand = w_masked;
                end else begin
                    w_hold_nxt = r_hold_cnt + HW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_win = f_winner(w_cand, r_ptr);
        if (w_take) begin
            w_state_nxt = S_GRANT;
            w_owner_nxt = w_win;
            w_hold_nxt  = HW'(1);
            w_ptr_nxt   = w_win + 3'd1;
            w_new_nxt   = 1'b1;
        end

        w_gnt_nxt = (w_state_nxt == S_GRANT) ? (8'b1 << w_owner_nxt) : 8'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= 3'd0;
            r_hold_cnt  <= '0;
            r_ptr       <= 3'd0;
            r_gnt       <= 8'b0;
            r_busy      <= 1'b0;
            r_new_grant <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_busy      <= (w_state_nxt == S_GRANT);
            r_new_grant <= w_new_nxt;
        end
    end

    // owner only changes on a new grant, so it doubles as the held select.
    assign bus.gnt       = r_gnt;
    assign bus.sel       = r_owner;
    assign bus.busy      = r_busy;
    assign bus.new_grant = r_new_grant;

endmodule

`default_nettype wire

// File: doc/mux_arbiter8.md
# mux_arbiter8

Registered round-robin arbiter that shares one 8:1 bit-select datapath (the 8-to-1 mux built from 4:1 and 2:1 stages) among eight requesters. It samples per-requester request lines and grants exactly one owner at a time. It drives the mux select with the owner's index and bounds each tenure with a hold limit. It sits between the requesting units and the mux select input; mux data and output are not routed through this block.

## Interface
- MAX_HOLD, default 4: maximum consecutive cycles one owner may keep the grant; legal range 1–16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i, level-sensitive.
- gnt  output  8  one-hot grant, or all-zero when idle; registered.
- sel  output  3  index of current owner, wired to the mux select; registered.
- busy  output  1  high while any grant is active.
- new_grant  output  1  one-cycle pulse in the first cycle of every tenure, including a re-grant to the same owner.

## Operation
- Reset is asynchronous and active-low. While rst_n=0, gnt=0, sel=0, busy=0, new_grant=0, ptr=0, hold_cnt=0 and state=IDLE. All of these clear immediately, including mid-tenure.
- Internal state:
  - ptr[2:0], the highest-priority index, reset 0.
  - hold_cnt, width $clog2(MAX_HOLD)+1, holding cycles elapsed in the current tenure.
  - owner[2:0].
- Winner selection: the first set bit of the candidate vector found by scanning indices ptr, ptr+1, …, ptr+7 modulo 8. The scan wraps from 7 to 0.
- State IDLE: gnt=0 and busy=0. sel keeps its last value, which is 0 after reset.
  - If req≠0 at an edge, go to GRANT, owner=winner(req), hold_cnt=1, ptr=winner+1 mod 8, new_grant=1.
- State GRANT: gnt=1<<owner, sel=owner, busy=1. The following are evaluated at each edge, in priority order:
  1. req[owner]=0 (release): candidates = req. If candidates≠0, grant winner(candidates) back-to-back. Otherwise go to IDLE with gnt=0.
  2. req[owner]=1 and hold_cnt==MAX_HOLD (limit): candidates = req with the owner bit masked.
     - If candidates≠0, grant winner(candidates).
     - Otherwise re-grant the same owner: hold_cnt=1, new_grant=1, ptr=owner+1.
  3. Otherwise (hold): keep the owner and set hold_cnt=hold_cnt+1.
- Every new grant sets hold_cnt=1, ptr=winner+1 mod 8 and new_grant=1 for one cycle.
- With MAX_HOLD=1, every cycle is a limit event, so requesters rotate every cycle.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit while busy=1.
- req bits for non-owners may change freely. The arbiter never preempts an owner before the hold limit.

## Timing
- Grant latency: req sampled at edge k, gnt/sel/busy valid after edge k. This is 1 cycle from request to grant.
- Hand-off has zero bubble: when the owner drops req at edge k and others are requesting, the new gnt appears after edge k.
- Release to idle: the owner drops req at edge k, and gnt=0 and busy=0 after edge k.
- Maximum tenure is MAX_HOLD cycles. Worst-case wait for a continuously requesting unit is 7×MAX_HOLD cycles plus 1 grant cycle.
- new_grant is high for exactly one cycle, coincident with the first cycle of the new gnt.
- All outputs are registered; there is no combinational path from req to any output.

## Test plan
- Reset/idle: hold rst_n=0 for 2 cycles with req=8'hFF, then release → gnt=0 during reset; gnt=8'h01, sel=0, new_grant=1 one cycle after release.
- Round-robin rotation (MAX_HOLD=4): req=8'hFF held constant → sel sequence 0,0,0,0,1,1,1,1,2,… with wrap 7→0, and new_grant on each change.
- Voluntary release and hand-off: req=8'h01 for 2 cycles, then 8'h10 → gnt=01,01,10 with no idle cycle, and sel=4 in the third cycle.
- Sole requester at limit: req=8'h08 for 10 cycles → gnt stays 8'h08 and busy stays 1. new_grant pulses at cycles 1, 5 and 9.
- Pointer fairness with wrap: ptr=7 (after serving 6), req=8'h81 → grant 7 first, then 0 on release.
- Async reset mid-tenure: assert rst_n=0 between edges while gnt=8'h20 → gnt, sel and busy go to 0 immediately, before the next edge; ptr restarts at 0.
